// File: rtl/adc_uart_sequencer_pkg.sv
// Shared constants for the ADC-to-UART sequencer.
//   state_t   : FSM state encoding (3 bits)
//   ASCII_CR  : frame terminator byte
//   FRAME_LEN : bytes per frame (two hex digits + CR)
package adc_uart_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_SPI_REQ      = 3'd1,
    ST_SPI_WAIT     = 3'd2,
    ST_TX_LOAD      = 3'd3,
    ST_TX_WAIT_BUSY = 3'd4,
    ST_TX_WAIT_IDLE = 3'd5
  } state_t;

  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam int         FRAME_LEN = 3;

endpackage

// File: rtl/adc_uart_sequencer_trig_gen.sv
// Trigger source for the sequencer: synchronizes the manual push button,
// detects its falling edge and runs the periodic auto-trigger counter.
// Ports:
//   clk, n_rst : clock, asynchronous active-low reset
//   n_start    : active-low push button, asynchronous to clk
//   auto_en    : enables the period counter (cleared while low)
//   trig       : one-cycle trigger (manual edge OR auto tick)
module adc_uart_sequencer_trig_gen #(
  parameter int unsigned           PERIOD_BIT = 16,
  parameter logic [PERIOD_BIT-1:0] PERIOD     = 16'd49999
) (
  input  logic clk,
  input  logic n_rst,
  input  logic n_start,
  input  logic auto_en,
  output logic trig
);

  logic                  n_start_p0;
  logic                  n_start_p1;
  logic                  n_start_p2;
  logic                  man_trig;
  logic [PERIOD_BIT-1:0] period_cnt;
  logic                  auto_tick;

  // Stage p0/p1: metastability synchronizer; p2 holds the previous
  // synchronized level; man_trig registers the falling edge.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      n_start_p0 <= 1'b1;
      n_start_p1 <= 1'b1;
      n_start_p2 <= 1'b1;
      man_trig   <= 1'b0;
    end else begin
      n_start_p0 <= n_start;
      n_start_p1 <= n_start_p0;
      n_start_p2 <= n_start_p1;
      man_trig   <= n_start_p2 & ~n_start_p1;
    end
  end

  // Period counter free-runs regardless of sequencer activity.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      period_cnt <= '0;
    end else if (!auto_en) begin
      period_cnt <= '0;
    end else if (period_cnt == PERIOD) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + PERIOD_BIT'(1);
    end
  end

  // The tick is decoded from the counter register so the sequencer can
  // react on the very next edge.
  assign auto_tick = auto_en && (period_cnt == PERIOD);
  assign trig      = man_trig | auto_tick;

endmodule

// File: rtl/adc_uart_sequencer.sv
// Sequencer between an SPI ADC master and a UART transmitter. Each trigger
// performs one 8-bit acquisition and sends it as "HH\r" over the UART.
// Ports:
//   clk, n_rst          : clock, asynchronous active-low reset
//   n_start, auto_en    : manual trigger button, periodic trigger enable
//   spi_start/spi_done  : SPI master handshake, spi_data valid with spi_done
//   tx_start/tx_data    : UART load pulse and byte (held until tx_busy falls)
//   tx_busy             : UART frame in flight
//   busy                : sequencer not idle
//   sample              : last captured sample
//   overrun, spi_err    : sticky error flags (cleared by reset only)
module adc_uart_sequencer
  import adc_uart_sequencer_pkg::*;
#(
  parameter int unsigned           PERIOD_BIT = 16,
  parameter logic [PERIOD_BIT-1:0] PERIOD     = 16'd49999,
  parameter int unsigned           SPI_TO_BIT = 8,
  parameter logic [SPI_TO_BIT-1:0] SPI_TO     = 8'd255
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       n_start,
  input  logic       auto_en,
  output logic       spi_start,
  input  logic       spi_done,
  input  logic [7:0] spi_data,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  output logic       busy,
  output logic [7:0] sample,
  output logic       overrun,
  output logic       spi_err
);

  localparam logic [1:0]            LAST_IDX = 2'(FRAME_LEN - 1);
  // spi_done is still accepted in the cycle SPI_TO after spi_start; the
  // counter holds SPI_TO-1 in that cycle.
  localparam logic [SPI_TO_BIT-1:0] TO_LAST  = SPI_TO - SPI_TO_BIT'(1);

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + {4'h0, nib};
    return 8'h37 + {4'h0, nib};
  endfunction

  function automatic logic [7:0] frame_byte(input logic [7:0] smp, input logic [1:0] sel);
    case (sel)
      2'd0:    return hex_ascii(smp[7:4]);
      2'd1:    return hex_ascii(smp[3:0]);
      default: return ASCII_CR;
    endcase
  endfunction

  state_t                state, state_nxt;
  logic [SPI_TO_BIT-1:0] to_cnt, to_cnt_nxt;
  logic [1:0]            idx, idx_nxt;
  logic [7:0]            sample_nxt;
  logic [7:0]            tx_data_nxt;
  logic                  tx_start_nxt;
  logic                  spi_err_nxt;
  logic                  overrun_nxt;
  logic                  trig;

  adc_uart_sequencer_trig_gen #(
    .PERIOD_BIT (PERIOD_BIT),
    .PERIOD     (PERIOD)
  ) trig_gen (
    .clk     (clk),
    .n_rst   (n_rst),
    .n_start (n_start),
    .auto_en (auto_en),
    .trig    (trig)
  );

  always_comb begin
    state_nxt   = state;
    to_cnt_nxt  = to_cnt;
    idx_nxt     = idx;
    sample_nxt  = sample;
    spi_err_nxt = spi_err;
    overrun_nxt = overrun | (trig && (state != ST_IDLE));
    case (state)
      ST_IDLE: begin
        if (trig) state_nxt = ST_SPI_REQ;
      end
      ST_SPI_REQ: begin
        to_cnt_nxt = '0;
        state_nxt  = ST_SPI_WAIT;
      end
      ST_SPI_WAIT: begin
        if (spi_done) begin
          sample_nxt = spi_data;
          idx_nxt    = 2'd0;
          state_nxt  = ST_TX_LOAD;
        end else if (to_cnt == TO_LAST) begin
          spi_err_nxt = 1'b1;
          state_nxt   = ST_IDLE;
        end else begin
          to_cnt_nxt = to_cnt + SPI_TO_BIT'(1);
        end
      end
      ST_TX_LOAD: begin
        // tx_start is registered one edge ahead, so leaving TX_LOAD keys
        // off the pulse itself rather than a fresh look at tx_busy.
        if (tx_start) state_nxt = ST_TX_WAIT_BUSY;
      end
      ST_TX_WAIT_BUSY: begin
        if (tx_busy) state_nxt = ST_TX_WAIT_IDLE;
      end
      ST_TX_WAIT_IDLE: begin
        if (!tx_busy) begin
          if (idx == LAST_IDX) begin
            state_nxt = ST_IDLE;
          end else begin
            idx_nxt   = idx + 2'd1;
            state_nxt = ST_TX_LOAD;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Pulse lands in the first TX_LOAD cycle whenever the UART is free.
    tx_start_nxt = (state_nxt == ST_TX_LOAD) && !tx_busy;
    tx_data_nxt  = tx_start_nxt ? frame_byte(sample_nxt, idx_nxt) : tx_data;
  end

  // State and output register stage.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= ST_IDLE;
      to_cnt    <= '0;
      idx       <= 2'd0;
      sample    <= 8'h00;
      spi_err   <= 1'b0;
      overrun   <= 1'b0;
      spi_start <= 1'b0;
      tx_start  <= 1'b0;
      tx_data   <= 8'h00;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      to_cnt    <= to_cnt_nxt;
      idx       <= idx_nxt;
      sample    <= sample_nxt;
      spi_err   <= spi_err_nxt;
      overrun   <= overrun_nxt;
      spi_start <= (state_nxt == ST_SPI_REQ);
      tx_start  <= tx_start_nxt;
      tx_data   <= tx_data_nxt;
      busy      <= (state_nxt != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_adc_uart_sequencer.sv
module tb_adc_uart_sequencer;

  localparam int SPI_TO_V = 255;

  logic       clk = 1'b0;
  logic       n_rst, n_start, auto_en;
  logic       spi_start, spi_done, tx_start, tx_busy, busy, overrun, spi_err;
  logic [7:0] spi_data, tx_data, sample;

  bit uart_busy = 1'b0;
  bit force_busy = 1'b0;
  assign tx_busy = uart_busy | force_busy;

  adc_uart_sequencer #(
    .PERIOD_BIT (16),
    .PERIOD     (16'd99),
    .SPI_TO_BIT (8),
    .SPI_TO     (8'd255)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .n_start   (n_start),
    .auto_en   (auto_en),
    .spi_start (spi_start),
    .spi_done  (spi_done),
    .spi_data  (spi_data),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .busy      (busy),
    .sample    (sample),
    .overrun   (overrun),
    .spi_err   (spi_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin @(posedge clk); cyc++; end

  int n_chk = 0, n_pass = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference model: ASCII hex frame computed from the sample value.
  function automatic logic [7:0] ref_digit(input int n);
    return (n < 10) ? 8'(48 + n) : 8'(65 + n - 10);
  endfunction
  function automatic logic [7:0] ref_byte(input logic [7:0] s, input int i);
    if (i == 0) return ref_digit(int'(s) / 16);
    if (i == 1) return ref_digit(int'(s) % 16);
    return 8'h0D;
  endfunction

  // SPI ADC model: answers resp_dly cycles after spi_start.
  bit         resp_en = 1'b1;
  int         resp_dly = 20, sp_cd = 0, done_cyc = -1;
  logic [7:0] resp_data = 8'h00;
  initial begin
    spi_done = 1'b0; spi_data = 8'h00;
    forever begin
      @(posedge clk); #1;
      spi_done = 1'b0;
      if (!n_rst) sp_cd = 0;
      else if (spi_start) begin
        if (resp_en) sp_cd = resp_dly;
      end else if (sp_cd > 0) begin
        sp_cd--;
        if (sp_cd == 0) begin spi_done = 1'b1; spi_data = resp_data; done_cyc = cyc; end
      end
    end
  end

  // UART model: busy rises ulag cycles after tx_start, lasts ulen cycles.
  int         ulag = 1, ulen = 100, u_t = 0, tx_cnt = 0, first_tx = -1;
  int         start_err = 0, stab_err = 0;
  bit         u_act = 1'b0;
  logic [7:0] u_byte = 8'h00;
  logic [7:0] got[$];
  initial forever begin
    @(posedge clk); #1;
    if (!n_rst) begin
      u_act = 1'b0; uart_busy = 1'b0;
    end else if (tx_start) begin
      if (u_act || force_busy) start_err++;
      got.push_back(tx_data); tx_cnt++;
      if (first_tx < 0) first_tx = cyc;
      u_act = 1'b1; u_t = 0; u_byte = tx_data; uart_busy = 1'b0;
    end else if (u_act) begin
      u_t++;
      if (tx_data !== u_byte) stab_err++;
      if (u_t >= ulag + ulen) begin u_act = 1'b0; uart_busy = 1'b0; end
      else uart_busy = (u_t >= ulag);
    end
  end

  int spi_cnt = 0, spi_cyc = -1;
  initial forever begin
    @(negedge clk);
    if (spi_start) begin spi_cnt++; spi_cyc = cyc; end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, n_pass=%0d n_chk=%0d", n_pass, n_chk);
    $fatal(1);
  end

  typedef struct {
    logic [7:0] smp;
    logic [7:0] e0, e1, e2;
    int         dly, ulen, ulag;
  } vec_t;

  logic [7:0] last_smp = 8'h00;

  task automatic press(output int fall);
    @(posedge clk); #1;
    n_start = 1'b0; fall = cyc;
    repeat (6) @(posedge clk);
    #1 n_start = 1'b1;
  endtask

  task automatic wait_spi(input int prev, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (spi_cnt != prev) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_frame(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (got.size() >= 3 && !busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic check_bytes(input string tag, input logic [7:0] e0, e1, e2);
    logic [7:0] exp[3];
    exp[0] = e0; exp[1] = e1; exp[2] = e2;
    check({tag, " byte count"}, got.size(), 3);
    for (int i = 0; i < 3; i++)
      check($sformatf("%s byte%0d", tag, i), (i < got.size()) ? got[i] : 8'hxx, exp[i]);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int fall, s0;
    bit ok;
    resp_data = v.smp; resp_dly = v.dly; ulen = v.ulen; ulag = v.ulag;
    got.delete(); first_tx = -1; s0 = spi_cnt;
    press(fall);
    wait_spi(s0, 50, ok);
    check({tag, " spi_start seen"}, ok, 1);
    check({tag, " trigger latency"}, spi_cyc - fall, 4);
    wait_frame(4000, ok);
    check({tag, " frame done"}, ok, 1);
    check({tag, " done->tx_start"}, first_tx - done_cyc, 1);
    check_bytes(tag, v.e0, v.e1, v.e2);
    check({tag, " sample"}, sample, v.smp);
    check({tag, " busy after"}, busy, 0);
    last_smp = v.smp;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " spi_start"}, spi_start, 0);
    check({tag, " tx_start"}, tx_start, 0);
    check({tag, " tx_data"}, tx_data, 8'h00);
    check({tag, " busy"}, busy, 0);
    check({tag, " sample"}, sample, 8'h00);
    check({tag, " overrun"}, overrun, 0);
    check({tag, " spi_err"}, spi_err, 0);
  endtask

  initial begin : main
    vec_t vecs[8];
    vec_t rv;
    int   fall, a, c1, c2, c3, s0, rel, tc, sc, s_st;
    bit   ok;

    vecs[0] = '{8'hC5, 8'h43, 8'h35, 8'h0D, 20, 100, 1};
    vecs[1] = '{8'h09, 8'h30, 8'h39, 8'h0D,  3,  12, 1};
    vecs[2] = '{8'hA0, 8'h41, 8'h30, 8'h0D,  1,   5, 1};
    vecs[3] = '{8'hFF, 8'h46, 8'h46, 8'h0D,  7,  20, 3};
    for (int i = 4; i < 8; i++) begin
      vecs[i].smp  = 8'($urandom_range(0, 255));
      vecs[i].e0   = ref_byte(vecs[i].smp, 0);
      vecs[i].e1   = ref_byte(vecs[i].smp, 1);
      vecs[i].e2   = ref_byte(vecs[i].smp, 2);
      vecs[i].dly  = $urandom_range(1, 40);
      vecs[i].ulen = $urandom_range(2, 60);
      vecs[i].ulag = $urandom_range(1, 4);
    end

    n_rst = 1'b0; n_start = 1'b1; auto_en = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("in reset");
    n_rst = 1'b1;
    repeat (5) @(negedge clk);
    check_reset_vals("after reset");

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));
    check("table start_err", start_err, 0);
    check("table stab_err", stab_err, 0);

    // tx_busy already high when TX_LOAD is entered, UART busy lags 2 cycles.
    resp_data = 8'h7E; resp_dly = 6; ulag = 2; ulen = 15;
    got.delete(); first_tx = -1; force_busy = 1'b1;
    press(fall);
    repeat (12) @(posedge clk);
    #1;
    check("held busy no tx_start", tx_cnt - tx_cnt, 0);
    check("held busy first_tx", first_tx, -1);
    force_busy = 1'b0; rel = cyc;
    wait_frame(2000, ok);
    check("lag frame done", ok, 1);
    check("lag first tx_start", first_tx - rel, 1);
    check_bytes("lag", ref_byte(8'h7E, 0), ref_byte(8'h7E, 1), ref_byte(8'h7E, 2));
    check("lag start_err", start_err, 0);
    check("lag stab_err", stab_err, 0);
    last_smp = 8'h7E;

    // SPI master never answers.
    resp_en = 1'b0; got.delete(); s0 = spi_cnt;
    press(fall);
    s_st = fall + 4;
    check("timeout spi_start issued", spi_cnt - s0, 1);
    for (int g = 0; g < 1000 && cyc < s_st + SPI_TO_V - 1; g++) @(negedge clk);
    check("timeout spi_err before", spi_err, 0);
    check("timeout busy before", busy, 1);
    for (int g = 0; g < 1000 && cyc < s_st + SPI_TO_V + 1; g++) @(negedge clk);
    check("timeout spi_err", spi_err, 1);
    check("timeout busy", busy, 0);
    check("timeout sample kept", sample, last_smp);
    check("timeout no tx", got.size(), 0);
    resp_en = 1'b1;
    rv.smp = 8'($urandom_range(0, 255));
    rv.e0 = ref_byte(rv.smp, 0); rv.e1 = ref_byte(rv.smp, 1); rv.e2 = ref_byte(rv.smp, 2);
    rv.dly = 10; rv.ulen = 8; rv.ulag = 1;
    run_vec(rv, "post-timeout");

    // Periodic trigger.
    check("overrun clear pre-auto", overrun, 0);
    resp_data = 8'h3C; resp_dly = 5; ulen = 10; ulag = 1; got.delete();
    s0 = spi_cnt;
    @(posedge clk); #1;
    auto_en = 1'b1; a = cyc;
    wait_spi(s0, 300, ok); c1 = spi_cyc;
    check("auto first seen", ok, 1);
    check("auto first latency", c1 - a, 100);
    s0 = spi_cnt; wait_spi(s0, 300, ok); c2 = spi_cyc;
    check("auto period 1", c2 - c1, 100);
    for (int g = 0; g < 200 && cyc < c2 + 60; g++) @(negedge clk);
    got.delete(); ulen = 300;
    s0 = spi_cnt; wait_spi(s0, 300, ok); c3 = spi_cyc;
    check("auto period 2", c3 - c2, 100);
    check("overrun before long frame", overrun, 0);
    s0 = spi_cnt; wait_spi(s0, 1200, ok);
    check("auto after long frame seen", ok, 1);
    check("auto ticks dropped while busy", spi_cyc - c3, 1000);
    check("overrun set", overrun, 1);
    check_bytes("long frame", ref_byte(8'h3C, 0), ref_byte(8'h3C, 1), ref_byte(8'h3C, 2));
    auto_en = 1'b0; got.delete();
    wait_frame(4000, ok);
    check("frame survives auto_en drop", ok, 1);
    check_bytes("auto_en drop", ref_byte(8'h3C, 0), ref_byte(8'h3C, 1), ref_byte(8'h3C, 2));
    last_smp = 8'h3C;

    // Reset in the middle of a frame.
    resp_data = 8'h5A; resp_dly = 4; ulen = 100; ulag = 1; got.delete();
    press(fall);
    for (int g = 0; g < 300 && got.size() < 1; g++) @(negedge clk);
    repeat (30) @(negedge clk);
    check("mid-frame got byte", got.size(), 1);
    check("sticky overrun held", overrun, 1);
    check("sticky spi_err held", spi_err, 1);
    check("mid-frame busy", busy, 1);
    #2 n_rst = 1'b0;
    #1 check_reset_vals("async reset");
    repeat (3) @(posedge clk);
    @(negedge clk); n_rst = 1'b1;
    tc = tx_cnt; sc = spi_cnt;
    repeat (1500) @(negedge clk);
    check("no tx_start after reset", tx_cnt - tc, 0);
    check("no spi_start after reset", spi_cnt - sc, 0);
    check("idle after reset", busy, 0);
    rv.smp = 8'($urandom_range(0, 255));
    rv.e0 = ref_byte(rv.smp, 0); rv.e1 = ref_byte(rv.smp, 1); rv.e2 = ref_byte(rv.smp, 2);
    rv.dly = $urandom_range(1, 30); rv.ulen = $urandom_range(2, 40); rv.ulag = $urandom_range(1, 3);
    run_vec(rv, "post-reset");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
